uart_frame_core: RTL and testbench
==================================

Name: uart_frame_core

Overview:
Parametrised framing core between the byte-level uart module and the miner datapath. Assembles a HEADER_BYTES-byte block header from received bytes and publishes it atomically. Serialises NONCE_BYTES-byte result words to the UART transmitter with selectable byte order and a one-deep pending queue. Adds an inter-byte receive timeout that resynchronises a partial header, and overflow reporting.

Parameters:
HEADER_BYTES, 80, bytes per header frame (header_data width = 8*HEADER_BYTES)
NONCE_BYTES, 4, bytes per transmitted result word
TX_MSB_FIRST, 1, 1 = send most-significant byte first; 0 = least-significant first
RX_TIMEOUT, 50000000, idle clocks after which a partial header is discarded (0 = disabled)
CNT_W, 32, width of byte_count

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
rx_byte  in  8  received byte from uart dout
rx_valid  in  1  uart rdy; level, held until cleared
rx_ack  out  1  uart rdy_clr; one-cycle pulse per accepted byte
header_data  out  8*HEADER_BYTES  last complete header; first-received byte in MSBs
header_valid  out  1  one-cycle pulse when header_data updates
rx_timeout  out  1  one-cycle pulse when a partial header is discarded
byte_count  out  CNT_W  total bytes accepted, wraps
nonce_input  in  8*NONCE_BYTES  result word to send
transmit_data  in  1  one-cycle request; samples nonce_input
tx_byte  out  8  uart din
tx_wr  out  1  uart wr_en; one-cycle pulse per byte
tx_busy  in  1  uart tx_busy
tx_active  out  1  high while a word is in flight or pending
tx_overflow  out  1  one-cycle pulse when a request is dropped

Behaviour:
- Reset: all outputs 0, header_data 0, byte index 0, timeout counter 0, TX state IDLE, pending empty. Reset mid-frame or mid-word abandons it; no further tx_wr.
- RX accept: when rx_valid && !rx_ack: shift byte into assembly register (left shift, new byte in LSBs), rx_ack=1 next cycle, byte_count+1, index+1. rx_ack forces one cycle of non-acceptance, so a held rx_valid is not double-counted.
- On accepting byte HEADER_BYTES-1: header_data <= assembled value including this byte, header_valid pulses the cycle after, index -> 0. header_data otherwise stable.
- Timeout: counter clears on every accepted byte and while index==0; increments otherwise. Reaching RX_TIMEOUT: index -> 0, counter -> 0, rx_timeout pulse, header_data unchanged. Acceptance on the same cycle as expiry wins (no timeout).
- TX FSM states: IDLE, ISSUE, ARM, DRAIN.
  - IDLE: on transmit_data, load shift register from nonce_input, remaining=NONCE_BYTES -> ISSUE.
  - ISSUE: if !tx_busy: tx_wr=1, tx_byte=current byte (MSB or LSB end per TX_MSB_FIRST), shift, remaining-1 -> ARM.
  - ARM: one wait cycle for uart to raise tx_busy -> DRAIN.
  - DRAIN: when !tx_busy: remaining>0 -> ISSUE; else if pending valid -> load pending, clear it -> ISSUE; else -> IDLE.
- Pending queue: transmit_data outside IDLE captures nonce_input if empty; if full, request dropped, pending unchanged, tx_overflow pulse. transmit_data in IDLE goes straight to the shift register.
- tx_active = (state != IDLE) || pending valid.
- tx_byte holds last value between writes. byte_count wraps 2^CNT_W-1 -> 0.

Test Plan:
- HEADER_BYTES=80: send bytes 0x00..0x4F -> one header_valid; header_data[639:632]=0x00, [7:0]=0x4F; byte_count=80; 80 rx_ack pulses.
- Hold rx_valid high 5 cycles with one byte -> exactly one rx_ack, byte_count+1.
- 10 bytes then idle RX_TIMEOUT=100 cycles -> rx_timeout at cycle 100, no header_valid; next 80 bytes form a clean header.
- nonce_input=0x90A14642, TX_MSB_FIRST=1, model tx_busy 10 cycles per byte -> tx_wr bytes 90,A1,46,42; with TX_MSB_FIRST=0 -> 42,46,A1,90.
- Requests 0x11111111, then 0x22222222 and 0x33333333 during first word -> 8 bytes 11..,22..; one tx_overflow; 0x33 never sent; tx_active falls after last DRAIN.
- Assert reset mid-word after 2 bytes -> no further tx_wr, tx_active=0, byte_count=0, header_data=0.

Source files
------------

// File: rtl/uart_frame_core.sv
// uart_frame_core: framing between the byte-level uart and the miner datapath.
// RX side assembles a HEADER_BYTES header (first byte ends up in the MSBs)
// and publishes it atomically. A partial header is dropped after RX_TIMEOUT
// idle clocks. TX side serialises NONCE_BYTES result words into the uart and
// keeps one further request pending.
//
// TX state | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing in flight; a request loads the shift register
// ISSUE    | waiting for the uart to be free, then writes one byte
// ARM      | one cycle for the uart to raise tx_busy after the write
// DRAIN    | waiting for the byte to leave; then next byte, pending or IDLE
module uart_frame_core #(
  parameter int unsigned HEADER_BYTES = 80,
  parameter int unsigned NONCE_BYTES  = 4,
  parameter bit          TX_MSB_FIRST = 1'b1,
  parameter int unsigned RX_TIMEOUT   = 50000000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_valid,
  output logic                       rx_ack,
  output logic [8*HEADER_BYTES-1:0]  header_data,
  output logic                       header_valid,
  output logic                       rx_timeout,
  output logic [CNT_W-1:0]           byte_count,
  input  logic [8*NONCE_BYTES-1:0]   nonce_input,
  input  logic                       transmit_data,
  output logic [7:0]                 tx_byte,
  output logic                       tx_wr,
  input  logic                       tx_busy,
  output logic                       tx_active,
  output logic                       tx_overflow
);

  localparam int unsigned HDR_W   = 8 * HEADER_BYTES;
  localparam int unsigned NONCE_W = 8 * NONCE_BYTES;
  localparam int unsigned IDX_W   = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
  localparam int unsigned TO_W    = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam int unsigned REM_W   = $clog2(NONCE_BYTES + 1);

  localparam bit               TO_EN    = (RX_TIMEOUT != 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HEADER_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RX_TIMEOUT - 1);
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(NONCE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ARM   = 2'd2,
    ST_DRAIN = 2'd3
  } tx_state_t;

  // ------------------------------------------------------------------
  // Receive path
  // ------------------------------------------------------------------
  logic [HDR_W-1:0] asm_q;
  logic [HDR_W-1:0] asm_next;
  logic [IDX_W-1:0] idx_q;
  logic [TO_W-1:0]  tmo_q;
  logic             rx_accept;
  logic             tmo_expire;

  // rx_ack high blocks acceptance for one cycle so a level-held rdy that the
  // uart is still clearing is not taken twice.
  assign rx_accept  = rx_valid && !rx_ack;
  assign asm_next   = (asm_q << 8) | HDR_W'(rx_byte);
  assign tmo_expire = TO_EN && !rx_accept && (idx_q != '0) && (tmo_q == TO_LAST);

  // Byte acceptance, header assembly/publish and the inter-byte idle timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_ack       <= 1'b0;
      asm_q        <= '0;
      header_data  <= '0;
      header_valid <= 1'b0;
      rx_timeout   <= 1'b0;
      byte_count   <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
    end else begin
      rx_ack       <= rx_accept;
      header_valid <= 1'b0;
      rx_timeout   <= 1'b0;
      if (rx_accept) begin
        asm_q      <= asm_next;
        byte_count <= byte_count + CNT_W'(1);
        tmo_q      <= '0;
        if (idx_q == IDX_LAST) begin
          header_data  <= asm_next;
          header_valid <= 1'b1;
          idx_q        <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end else if (tmo_expire) begin
        // stale bytes left in asm_q are shifted out by the next full header
        idx_q      <= '0;
        tmo_q      <= '0;
        rx_timeout <= 1'b1;
      end else if ((idx_q == '0) || !TO_EN) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TO_W'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Transmit path
  // ------------------------------------------------------------------
  tx_state_t          state_q;
  tx_state_t          state_d;
  logic [NONCE_W-1:0] tx_sh_q;
  logic [NONCE_W-1:0] sh_next;
  logic [REM_W-1:0]   rem_q;
  logic [NONCE_W-1:0] pend_data_q;
  logic               pend_valid_q;
  logic [7:0]         cur_byte;
  logic               load_new;
  logic               load_pend;
  logic               issue;

  assign cur_byte  = TX_MSB_FIRST ? tx_sh_q[NONCE_W-1 -: 8] : tx_sh_q[7:0];
  assign sh_next   = TX_MSB_FIRST ? (tx_sh_q << 8) : (tx_sh_q >> 8);
  assign tx_active = (state_q != ST_IDLE) || pend_valid_q;

  // TX state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // TX next-state and datapath strobes.
  always_comb begin
    state_d   = state_q;
    load_new  = 1'b0;
    load_pend = 1'b0;
    issue     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (transmit_data) begin
          load_new = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!tx_busy) begin
          issue   = 1'b1;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!tx_busy) begin
          if (rem_q != '0) begin
            state_d = ST_ISSUE;
          end else if (pend_valid_q) begin
            load_pend = 1'b1;
            state_d   = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift register, byte counter, uart write strobe and the pending slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_sh_q      <= '0;
      rem_q        <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      tx_wr        <= 1'b0;
      tx_byte      <= '0;
      tx_overflow  <= 1'b0;
    end else begin
      tx_wr       <= issue;
      tx_overflow <= 1'b0;
      if (issue) begin
        tx_byte <= cur_byte;
        tx_sh_q <= sh_next;
        rem_q   <= rem_q - REM_W'(1);
      end
      if (load_new) begin
        tx_sh_q <= nonce_input;
        rem_q   <= REM_INIT;
      end
      if (load_pend) begin
        tx_sh_q      <= pend_data_q;
        rem_q        <= REM_INIT;
        pend_valid_q <= 1'b0;
      end
      // a full slot at request time drops the request, even if it is being
      // emptied on the same cycle
      if (transmit_data && (state_q != ST_IDLE)) begin
        if (!pend_valid_q) begin
          pend_data_q  <= nonce_input;
          pend_valid_q <= 1'b1;
        end else begin
          tx_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_core.sv
// Bench for uart_frame_core: one instance sends MSB first, one LSB first;
// both share the same stimulus. A simple uart model drives tx_busy.
module tb_uart_frame_core;

  localparam int HB = 80;
  localparam int NB = 4;
  localparam int TO = 100;

  logic              clock = 1'b0;
  logic              reset;
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic [8*NB-1:0]   nonce_input;
  logic              transmit_data;
  logic              tx_busy_m = 1'b0;
  logic              tx_busy_l = 1'b0;

  logic              rx_ack_m, rx_ack_l;
  logic [8*HB-1:0]   header_data_m, header_data_l;
  logic              header_valid_m, header_valid_l;
  logic              rx_timeout_m, rx_timeout_l;
  logic [31:0]       byte_count_m, byte_count_l;
  logic [7:0]        tx_byte_m, tx_byte_l;
  logic              tx_wr_m, tx_wr_l;
  logic              tx_active_m, tx_active_l;
  logic              tx_overflow_m, tx_overflow_l;

  uart_frame_core #(.HEADER_BYTES(HB), .NONCE_BYTES(NB), .TX_MSB_FIRST(1'b1),
                    .RX_TIMEOUT(TO), .CNT_W(32)) dut_m (
    .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_ack(rx_ack_m), .header_data(header_data_m), .header_valid(header_valid_m),
    .rx_timeout(rx_timeout_m), .byte_count(byte_count_m), .nonce_input(nonce_input),
    .transmit_data(transmit_data), .tx_byte(tx_byte_m), .tx_wr(tx_wr_m),
    .tx_busy(tx_busy_m), .tx_active(tx_active_m), .tx_overflow(tx_overflow_m));

  uart_frame_core #(.HEADER_BYTES(HB), .NONCE_BYTES(NB), .TX_MSB_FIRST(1'b0),
                    .RX_TIMEOUT(TO), .CNT_W(32)) dut_l (
    .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_ack(rx_ack_l), .header_data(header_data_l), .header_valid(header_valid_l),
    .rx_timeout(rx_timeout_l), .byte_count(byte_count_l), .nonce_input(nonce_input),
    .transmit_data(transmit_data), .tx_byte(tx_byte_l), .tx_wr(tx_wr_l),
    .tx_busy(tx_busy_l), .tx_active(tx_active_l), .tx_overflow(tx_overflow_l));

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [8*HB-1:0] act, input logic [8*HB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_q(input string nm, input logic [7:0] act[$], input logic [7:0] exp[$]);
    chk({nm, "_len"}, 64'(act.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk(nm, act[i], exp[i]);
  endtask

  // ---------------- monitors ----------------
  int hv_cnt = 0, tmo_cnt = 0, ack_cnt = 0, ovf_m = 0, ovf_l = 0;
  logic [8*HB-1:0] hdr_q[$];
  logic [7:0]      txq_m[$];
  logic [7:0]      txq_l[$];

  always @(negedge clock) begin
    if (header_valid_m) begin
      hv_cnt++;
      hdr_q.push_back(header_data_m);
    end
    if (rx_timeout_m) tmo_cnt++;
    if (rx_ack_m) ack_cnt++;
    if (tx_wr_m) txq_m.push_back(tx_byte_m);
    if (tx_wr_l) txq_l.push_back(tx_byte_l);
    if (tx_overflow_m) ovf_m++;
    if (tx_overflow_l) ovf_l++;
  end

  // ---------------- uart transmitter model ----------------
  bit rand_busy = 1'b0;
  int bl_m = 0, bl_l = 0;

  always @(negedge clock) begin
    if (reset) begin
      bl_m = 0; tx_busy_m = 1'b0;
    end else if (tx_wr_m) begin
      bl_m = rand_busy ? int'($urandom_range(1, 12)) : 10;
      tx_busy_m = 1'b1;
    end else if (bl_m > 0) begin
      bl_m--;
      if (bl_m == 0) tx_busy_m = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      bl_l = 0; tx_busy_l = 1'b0;
    end else if (tx_wr_l) begin
      bl_l = rand_busy ? int'($urandom_range(1, 12)) : 10;
      tx_busy_l = 1'b1;
    end else if (bl_l > 0) begin
      bl_l--;
      if (bl_l == 0) tx_busy_l = 1'b0;
    end
  end

  // ---------------- reference helpers ----------------
  function automatic logic [7:0] word_byte(input logic [31:0] w, input int i, input bit msb);
    return msb ? w[8*(NB-1-i) +: 8] : w[8*i +: 8];
  endfunction

  function automatic logic [8*HB-1:0] pack_hdr(input logic [7:0] q[$]);
    logic [8*HB-1:0] h;
    h = '0;
    foreach (q[i]) h = (h << 8) | (8*HB)'(q[i]);
    return h;
  endfunction

  // present one byte as a level held until the core acknowledges it
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_byte  = b;
    rx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rx_ack_m && n < 10);
    chk("rx_ack_seen", rx_ack_m, 1'b1);
    rx_valid = 1'b0;
  endtask

  task automatic start_req(input logic [31:0] w);
    transmit_data = 1'b1;
    nonce_input   = w;
    @(negedge clock);
    transmit_data = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while ((tx_active_m || tx_active_l || tx_busy_m || tx_busy_l) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(nm, {tx_active_m, tx_active_l}, 2'b00);
  endtask

  typedef struct {
    logic [31:0] nonce;
    logic [31:0] exp_msb;
    logic [31:0] exp_lsb;
  } tx_vec_t;

  tx_vec_t vecs[5];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ack0, hv0, tmo0, ovf0m, ovf0l, eovf, k, g, r, widx, n;
    int unsigned exp_bc;
    logic [7:0]      seq[$];
    logic [7:0]      em[$];
    logic [7:0]      el[$];
    logic [7:0]      win[$];
    logic [8*HB-1:0] exp_hdrs[$];
    logic [8*HB-1:0] hd;
    logic [31:0]     w, pm, pl;
    logic [7:0]      b;

    vecs[0] = '{32'h90A14642, 32'h90A14642, 32'h4246A190};
    vecs[1] = '{32'h00000000, 32'h00000000, 32'h00000000};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[3] = '{32'h01020304, 32'h01020304, 32'h04030201};
    vecs[4] = '{32'h80FF0001, 32'h80FF0001, 32'h0100FF80};

    reset = 1'b1; rx_valid = 1'b0; rx_byte = '0;
    transmit_data = 1'b0; nonce_input = '0;
    exp_bc = 0;
    repeat (3) @(negedge clock);

    // reset state
    chk("rst_rx_ack", rx_ack_m, 1'b0);
    chk_wide("rst_header_data", header_data_m, '0);
    chk("rst_header_valid", header_valid_m, 1'b0);
    chk("rst_rx_timeout", rx_timeout_m, 1'b0);
    chk("rst_byte_count", byte_count_m, 32'd0);
    chk("rst_tx_wr", {tx_wr_m, tx_wr_l}, 2'b00);
    chk("rst_tx_byte", {tx_byte_m, tx_byte_l}, 16'h0);
    chk("rst_tx_active", {tx_active_m, tx_active_l}, 2'b00);
    chk("rst_tx_overflow", tx_overflow_m, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // header 0x00..0x4F
    ack0 = ack_cnt; hv0 = hv_cnt;
    seq.delete();
    for (int i = 0; i < HB; i++) begin
      send_byte(8'(i));
      seq.push_back(8'(i));
      exp_bc++;
    end
    repeat (3) @(negedge clock);
    chk("hdr_valid_count", 64'(hv_cnt - hv0), 64'd1);
    chk("hdr_ack_count", 64'(ack_cnt - ack0), 64'd80);
    chk("hdr_byte_count", byte_count_m, exp_bc);
    hd = header_data_m;
    chk("hdr_first_byte", hd[8*HB-1 -: 8], 8'h00);
    chk("hdr_last_byte", hd[7:0], 8'h4F);
    chk_wide("hdr_full", hd, pack_hdr(seq));

    // one held byte counts once
    ack0 = ack_cnt; hv0 = hv_cnt; tmo0 = tmo_cnt;
    send_byte(8'hA0);
    exp_bc++;
    repeat (2) @(negedge clock);
    chk("held_ack_count", 64'(ack_cnt - ack0), 64'd1);
    chk("held_byte_count", byte_count_m, exp_bc);

    // 10 bytes then idle: timeout exactly RX_TIMEOUT clocks after last accept
    for (int i = 1; i < 10; i++) begin
      send_byte(8'(8'hA0 + i));
      exp_bc++;
    end
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!rx_timeout_m && k < 150);
    chk("timeout_cycle", 64'(k), 64'(TO));
    repeat (2) @(negedge clock);
    chk("timeout_count", 64'(tmo_cnt - tmo0), 64'd1);
    chk("timeout_no_header", 64'(hv_cnt - hv0), 64'd0);
    chk_wide("timeout_header_kept", header_data_m, pack_hdr(seq));

    // clean header after resync
    seq.delete();
    for (int i = 0; i < HB; i++) begin
      send_byte(8'(8'h80 + i));
      seq.push_back(8'(8'h80 + i));
      exp_bc++;
    end
    repeat (3) @(negedge clock);
    chk("resync_hdr_count", 64'(hv_cnt - hv0), 64'd1);
    chk_wide("resync_hdr", header_data_m, pack_hdr(seq));

    // gap of RX_TIMEOUT-1: acceptance wins, then a full gap expires
    tmo0 = tmo_cnt;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'h10 + i));
      exp_bc++;
    end
    repeat (TO - 1) @(negedge clock);
    send_byte(8'h13);
    exp_bc++;
    repeat (2) @(negedge clock);
    chk("edge_gap_no_timeout", 64'(tmo_cnt - tmo0), 64'd0);
    k = 2;
    do begin
      @(negedge clock);
      k++;
    end while (!rx_timeout_m && k < 150);
    chk("edge_gap_timeout_cycle", 64'(k), 64'(TO));
    chk("edge_byte_count", byte_count_m, exp_bc);

    // table-driven single words, fixed 10-cycle uart
    rand_busy = 1'b0;
    for (int v = 0; v < 5; v++) begin
      txq_m.delete(); txq_l.delete();
      start_req(vecs[v].nonce);
      wait_idle(400, "vec_idle");
      repeat (2) @(negedge clock);
      chk("vec_len_msb", 64'(txq_m.size()), 64'(NB));
      chk("vec_len_lsb", 64'(txq_l.size()), 64'(NB));
      pm = '0; pl = '0;
      foreach (txq_m[i]) pm = (pm << 8) | 32'(txq_m[i]);
      foreach (txq_l[i]) pl = (pl << 8) | 32'(txq_l[i]);
      chk("vec_msb_order", pm, vecs[v].exp_msb);
      chk("vec_lsb_order", pl, vecs[v].exp_lsb);
    end

    // pending slot and overflow
    txq_m.delete(); txq_l.delete();
    ovf0m = ovf_m; ovf0l = ovf_l;
    transmit_data = 1'b1;
    nonce_input = 32'h11111111;
    @(negedge clock);
    nonce_input = 32'h22222222;
    @(negedge clock);
    nonce_input = 32'h33333333;
    @(negedge clock);
    transmit_data = 1'b0;
    chk("ovf_active", tx_active_m, 1'b1);
    wait_idle(600, "ovf_idle");
    repeat (2) @(negedge clock);
    em.delete();
    for (int i = 0; i < NB; i++) em.push_back(8'h11);
    for (int i = 0; i < NB; i++) em.push_back(8'h22);
    cmp_q("ovf_bytes_msb", txq_m, em);
    cmp_q("ovf_bytes_lsb", txq_l, em);
    chk("ovf_pulses_msb", 64'(ovf_m - ovf0m), 64'd1);
    chk("ovf_pulses_lsb", 64'(ovf_l - ovf0l), 64'd1);

    // random bursts of 1..4 requests against a random-latency uart
    rand_busy = 1'b1;
    txq_m.delete(); txq_l.delete(); em.delete(); el.delete();
    ovf0m = ovf_m; ovf0l = ovf_l; eovf = 0;
    for (int rr = 0; rr < 20; rr++) begin
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) begin
        w = $urandom;
        start_req(w);
        if (j < 2) begin
          for (int i = 0; i < NB; i++) begin
            em.push_back(word_byte(w, i, 1'b1));
            el.push_back(word_byte(w, i, 1'b0));
          end
        end else begin
          eovf++;
        end
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      wait_idle(800, "rand_tx_idle");
    end
    repeat (2) @(negedge clock);
    cmp_q("rand_tx_msb", txq_m, em);
    cmp_q("rand_tx_lsb", txq_l, el);
    chk("rand_ovf_msb", 64'(ovf_m - ovf0m), 64'(eovf));
    chk("rand_ovf_lsb", 64'(ovf_l - ovf0l), 64'(eovf));

    // random receive stream with occasional long gaps
    hdr_q.delete(); exp_hdrs.delete(); win.delete();
    tmo0 = tmo_cnt; widx = 0; k = 0;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      case (r)
        0: g = TO - 2;
        1: g = TO - 1;
        2: g = TO;
        3: g = TO + 1;
        default: g = int'($urandom_range(0, 3));
      endcase
      b = 8'($urandom);
      repeat (g) @(negedge clock);
      if (widx != 0 && g >= TO) begin
        k++;
        widx = 0;
        win.delete();
      end
      send_byte(b);
      exp_bc++;
      win.push_back(b);
      widx++;
      if (widx == HB) begin
        exp_hdrs.push_back(pack_hdr(win));
        win.delete();
        widx = 0;
      end
    end
    repeat (TO + 10) @(negedge clock);
    if (widx != 0) k++;
    chk("rand_rx_hdr_count", 64'(hdr_q.size()), 64'(exp_hdrs.size()));
    for (int i = 0; i < exp_hdrs.size() && i < hdr_q.size(); i++)
      chk_wide("rand_rx_hdr", hdr_q[i], exp_hdrs[i]);
    chk("rand_rx_timeouts", 64'(tmo_cnt - tmo0), 64'(k));
    chk("rand_rx_byte_count", byte_count_m, exp_bc);
    chk("rand_rx_byte_count_l", byte_count_l, exp_bc);

    // reset in the middle of a word
    rand_busy = 1'b0;
    txq_m.delete(); txq_l.delete();
    start_req(32'hA5B6C7D8);
    n = 0;
    while (txq_m.size() < 2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("midrst_bytes_before", 64'(txq_m.size()), 64'd2);
    if (txq_m.size() >= 2) begin
      chk("midrst_byte0", txq_m[0], 8'hA5);
      chk("midrst_byte1", txq_m[1], 8'hB6);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    txq_m.delete(); txq_l.delete();
    repeat (60) @(negedge clock);
    chk("midrst_no_tx_wr", 64'(txq_m.size() + txq_l.size()), 64'd0);
    chk("midrst_tx_active", {tx_active_m, tx_active_l}, 2'b00);
    chk("midrst_byte_count", byte_count_m, 32'd0);
    chk_wide("midrst_header_data", header_data_m, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
